// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the RV32 instruction-fetch stage.
package if_fetch_stage_pkg;

    localparam logic [31:0] BUBBLE_INSTR     = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'h0000_0004;

    typedef enum logic [1:0] {
        FETCH_BOOT  = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fb_entry_t;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/if_fetch_stage_chk.sv
// Invariant checker for the fetch stage: credit accounting and fetch-buffer overflow.
module if_fetch_stage_chk #(
    parameter int FB_DEPTH = 2,
    localparam int CW = $clog2(FB_DEPTH + 1)
) (
    input logic          clk,
    input logic          rst_n,
    input logic          push,
    input logic          pop,
    input logic          full,
    input logic [CW-1:0] outst,
    input logic [CW-1:0] fb_count
);

    logic [CW:0] credit_sum_s;
    assign credit_sum_s = {1'b0, outst} + {1'b0, fb_count};

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n) credit_sum_s <= (CW+1)'(FB_DEPTH));

endmodule

// File: rtl/if_fetch_stage_fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs; clear wins over push.
module fetch_fifo
    import if_fetch_stage_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fb_entry_t     push_data,
    input  logic          pop,
    input  logic          clear,
    output fb_entry_t     head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    fb_entry_t     mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1'b1);
        end
    endfunction

    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == {CW{1'b0}});
    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

    // Qualify requests: pop needs data; a push into a full FIFO is only taken with a pop.
    always_comb begin
        pop_ok_s  = pop && !empty;
        push_ok_s = push && (!full || pop_ok_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {$bits(fb_entry_t){1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (clear) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// RV32 instruction-fetch stage: PC, credit-limited imem requests, fetch buffer and IF/ID register.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          FB_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        pc_write,
    input  logic        ifid_write,
    input  logic        if_flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic        ifid_valid
);

    localparam int CW = $clog2(FB_DEPTH + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

    fetch_state_e  state_r;
    logic [31:0]   fetch_pc_r;
    logic [31:0]   resp_pc_r;
    logic [CW-1:0] outst_r;
    logic [CW-1:0] drop_cnt_r;
    logic [31:0]   ifid_instr_r;
    logic [31:0]   ifid_pc_r;
    logic          ifid_valid_r;

    logic          resp_s;
    logic          drop_s;
    logic          push_s;
    logic          pop_s;
    logic          accept_s;
    logic          req_s;
    logic [CW:0]   credit_sum_s;
    logic [CW-1:0] inflight_after_s;
    logic [CW-1:0] outst_nxt_s;
    fb_entry_t     push_data_s;
    fb_entry_t     fb_head_s;
    logic [CW-1:0] fb_count_s;
    logic          fb_full_s;
    logic          fb_empty_s;

    // Request/response qualification; rvalid with nothing in flight is a stale pre-reset return.
    always_comb begin
        resp_s           = imem_rvalid && (outst_r != CNT_ZERO);
        drop_s           = resp_s && ((drop_cnt_r != CNT_ZERO) || redirect_valid);
        push_s           = resp_s && !drop_s;
        pop_s            = ifid_write && !redirect_valid && !if_flush && !fb_empty_s;
        credit_sum_s     = {1'b0, outst_r} + {1'b0, fb_count_s};
        req_s            = (state_r == FETCH_RUN) && pc_write && !redirect_valid &&
                           (credit_sum_s < (CW+1)'(FB_DEPTH));
        accept_s         = req_s && imem_ready;
        inflight_after_s = resp_s ? (outst_r - CNT_ONE) : outst_r;
        push_data_s      = '{pc: resp_pc_r, instr: imem_rdata};
        case ({accept_s, resp_s})
            2'b10:   outst_nxt_s = outst_r + CNT_ONE;
            2'b01:   outst_nxt_s = outst_r - CNT_ONE;
            default: outst_nxt_s = outst_r;
        endcase
    end

    assign imem_req   = req_s;
    assign imem_addr  = fetch_pc_r;
    assign ifid_instr = ifid_instr_r;
    assign ifid_pc    = ifid_pc_r;
    assign ifid_valid = ifid_valid_r;

    // Control FSM, in-flight credit and drop counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= FETCH_BOOT;
            outst_r    <= CNT_ZERO;
            drop_cnt_r <= CNT_ZERO;
        end else begin
            outst_r <= outst_nxt_s;
            if (redirect_valid) begin
                drop_cnt_r <= inflight_after_s;
            end else if (drop_s) begin
                drop_cnt_r <= drop_cnt_r - CNT_ONE;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
            case (state_r)
                FETCH_BOOT:  state_r <= FETCH_RUN;
                FETCH_RUN:   state_r <= (redirect_valid && (inflight_after_s != CNT_ZERO)) ?
                                        FETCH_DRAIN : FETCH_RUN;
                FETCH_DRAIN: state_r <= (drop_cnt_r == CNT_ZERO) ? FETCH_RUN : FETCH_DRAIN;
                default:     state_r <= FETCH_BOOT;
            endcase
        end
    end

    // Fetch PC (next request) and response PC (tag for the next returned word).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r <= RESET_PC;
            resp_pc_r  <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc_r <= redirect_pc;
            resp_pc_r  <= redirect_pc;
        end else begin
            if (accept_s) begin
                fetch_pc_r <= pc_next(fetch_pc_r);
            end
            if (push_s) begin
                resp_pc_r <= pc_next(resp_pc_r);
            end
        end
    end

    // IF/ID pipeline register; a bubble keeps the previous pc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_instr_r <= BUBBLE_INSTR;
            ifid_pc_r    <= 32'h0000_0000;
            ifid_valid_r <= 1'b0;
        end else if (ifid_write) begin
            if (pop_s) begin
                ifid_instr_r <= fb_head_s.instr;
                ifid_pc_r    <= fb_head_s.pc;
                ifid_valid_r <= 1'b1;
            end else begin
                ifid_instr_r <= BUBBLE_INSTR;
                ifid_pc_r    <= ifid_pc_r;
                ifid_valid_r <= 1'b0;
            end
        end else begin
            ifid_instr_r <= ifid_instr_r;
            ifid_pc_r    <= ifid_pc_r;
            ifid_valid_r <= ifid_valid_r;
        end
    end

    fetch_fifo #(
        .DEPTH (FB_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .clear     (redirect_valid),
        .head      (fb_head_s),
        .count     (fb_count_s),
        .full      (fb_full_s),
        .empty     (fb_empty_s)
    );

    if_fetch_stage_chk #(
        .FB_DEPTH (FB_DEPTH)
    ) u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_s),
        .pop      (pop_s),
        .full     (fb_full_s),
        .outst    (outst_r),
        .fb_count (fb_count_s)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized scoreboard bench for if_fetch_stage with an in-order latency memory model.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;
    localparam int          CREDITS  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        pc_write;
    logic        ifid_write;
    logic        if_flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic        ifid_valid;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    exp_t  exp_q[$];
    mreq_t mq[$];
    int    cyc = 0;
    int    total = 0;
    int    bad = 0;
    int    delivered = 0;
    int    last_due = 0;
    logic [31:0] exp_fetch = RESET_PC;
    bit    real_resp = 1'b0;
    bit    w_e = 1'b0;
    bit    f_e = 1'b0;
    bit    r_e = 1'b0;
    bit    rst_e = 1'b0;
    logic [31:0] prev_instr = 32'h0;
    logic [31:0] prev_pc = 32'h0;
    logic        prev_valid = 1'b0;

    if_fetch_stage #(.RESET_PC(RESET_PC), .FB_DEPTH(CREDITS)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .if_flush       (if_flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_valid     (ifid_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // One clock of stimulus: drive at negedge, update the reference model just before posedge.
    task automatic do_cycle(input bit rst_val, input bit drain);
        bit was_reset;
        logic [31:0] t;
        int lat;
        int due;
        @(negedge clk);
        was_reset = !rst_n;
        rst_n = rst_val;
        real_resp = 1'b0;
        if (!rst_val || was_reset) begin
            // Stale returns from requests that the reset has killed.
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
            mq.delete();
            exp_q.delete();
            exp_fetch = RESET_PC;
            last_due  = 0;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mq[0].addr ^ DATA_KEY;
            real_resp   = 1'b1;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        imem_ready = ($urandom_range(0, 3) != 0);
        if (drain || !rst_val) begin
            pc_write = 1'b0; ifid_write = 1'b1; if_flush = 1'b0; redirect_valid = 1'b0;
        end else begin
            pc_write       = ($urandom_range(0, 9) != 0);
            ifid_write     = ($urandom_range(0, 6) != 0);
            if_flush       = ($urandom_range(0, 11) == 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
        end
        case ($urandom_range(0, 3))
            0:       redirect_pc = 32'hFFFF_FFF8;
            1:       redirect_pc = 32'h0000_0100;
            default: begin t = $urandom_range(0, 1023); redirect_pc = t << 2; end
        endcase
        #4;
        w_e = ifid_write; f_e = if_flush; r_e = redirect_valid; rst_e = rst_n;
        if (rst_n) begin
            if (real_resp) void'(mq.pop_front());
            if (redirect_valid) begin
                chk(imem_req == 1'b0, "req_on_redirect", {31'd0, imem_req}, 32'd0);
                exp_q.delete();
                exp_fetch = redirect_pc;
            end
            if (!pc_write) chk(imem_req == 1'b0, "req_while_pc_hold", {31'd0, imem_req}, 32'd0);
            if (imem_req && imem_ready) begin
                chk(imem_addr == exp_fetch, "imem_addr", imem_addr, exp_fetch);
                lat = $urandom_range(1, 3);
                due = cyc + lat;
                if (due < last_due) due = last_due;
                last_due = due;
                mq.push_back('{addr: imem_addr, due: due});
                exp_q.push_back('{pc: exp_fetch, instr: exp_fetch ^ DATA_KEY});
                exp_fetch = exp_fetch + 32'd4;
                chk(mq.size() <= CREDITS, "credit_limit", mq.size(), CREDITS);
            end
        end
    endtask

    // Monitor: judge the IF/ID register after every edge against the expected stream.
    always @(posedge clk) begin
        #1;
        if (!rst_e) begin
            chk(ifid_valid == 1'b0, "rst_valid", {31'd0, ifid_valid}, 32'd0);
            chk(ifid_instr == 32'h0, "rst_instr", ifid_instr, 32'h0);
            chk(ifid_pc == 32'h0, "rst_pc", ifid_pc, 32'h0);
            chk(imem_req == 1'b0, "rst_req", {31'd0, imem_req}, 32'd0);
        end else if (!w_e) begin
            chk(ifid_instr == prev_instr, "hold_instr", ifid_instr, prev_instr);
            chk(ifid_pc == prev_pc, "hold_pc", ifid_pc, prev_pc);
            chk(ifid_valid == prev_valid, "hold_valid", {31'd0, ifid_valid}, {31'd0, prev_valid});
        end else if (r_e || f_e) begin
            chk(ifid_valid == 1'b0, "kill_valid", {31'd0, ifid_valid}, 32'd0);
            chk(ifid_instr == 32'h0, "kill_instr", ifid_instr, 32'h0);
            chk(ifid_pc == prev_pc, "kill_pc", ifid_pc, prev_pc);
        end else if (ifid_valid) begin
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_instr", ifid_pc, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk(ifid_pc == e.pc, "ifid_pc", ifid_pc, e.pc);
                chk(ifid_instr == e.instr, "ifid_instr", ifid_instr, e.instr);
                delivered++;
            end
        end else begin
            chk(ifid_instr == 32'h0, "bubble_instr", ifid_instr, 32'h0);
        end
        prev_instr = ifid_instr;
        prev_pc    = ifid_pc;
        prev_valid = ifid_valid;
    end

    initial begin
        rst_n = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        pc_write = 1'b0; ifid_write = 1'b0; if_flush = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        for (int c = 0; c < 3400; c++) begin
            do_cycle(!(c < 3 || (c >= 1500 && c < 1504)), c >= 3340);
        end
        @(negedge clk);
        chk(exp_q.size() == 0, "stream_drained", exp_q.size(), 32'd0);
        chk(mq.size() == 0, "mem_drained", mq.size(), 32'd0);
        chk(delivered >= 200, "progress", delivered, 32'd200);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
